// File: rtl/rns_sub_scheduler.sv
// rns_sub_scheduler: time-multiplexed three-channel RNS modular subtractor with valid/ready handshake
module rns_sub_scheduler #(
  parameter int unsigned M0 = 7,
  parameter int unsigned M1 = 5,
  parameter int unsigned M2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] a_res,
  input  logic [8:0] b_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] diff,
  output logic       out_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [3:0] MW0 = 4'(M0);
  localparam logic [3:0] MW1 = 4'(M1);
  localparam logic [3:0] MW2 = 4'(M2);
  state_t state, state_nxt;
  logic [1:0] ch;
  logic [8:0] a_q, b_q;
  logic [3:0] a, b, m;
  logic [2:0] res;
  logic err;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // Shared subtractor: select the active channel, flag out-of-range residues, wrap negative results by adding the modulus
  always_comb begin
    a   = {1'b0, ch == 2'd0 ? a_q[2:0] : ch == 2'd1 ? a_q[5:3] : a_q[8:6]};
    b   = {1'b0, ch == 2'd0 ? b_q[2:0] : ch == 2'd1 ? b_q[5:3] : b_q[8:6]};
    m   = ch == 2'd0 ? MW0 : ch == 2'd1 ? MW1 : MW2;
    err = (a >= m) || (b >= m);
    res = err ? 3'd0 : 3'(a >= b ? a - b : a + m - b);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: accept in IDLE, three CALC cycles, hold DONE until the consumer takes the result
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (ch == 2'd2) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Operand latch on accept, then one channel result written per CALC cycle; error flag is sticky per operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff    <= '0;
      out_err <= 1'b0;
      ch      <= 2'd0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= a_res;
      b_q     <= b_res;
      out_err <= 1'b0;
      ch      <= 2'd0;
    end else if (state == CALC) begin
      ch      <= ch == 2'd2 ? 2'd0 : ch + 2'd1;
      out_err <= out_err | err;
      case (ch)
        2'd0:    diff[2:0] <= res;
        2'd1:    diff[5:3] <= res;
        default: diff[8:6] <= res;
      endcase
    end
endmodule

// File: tb/tb_rns_sub_scheduler.sv
// tb_rns_sub_scheduler: scoreboard bench for the RNS subtract sequencer
module tb_rns_sub_scheduler;
  localparam int M0 = 7, M1 = 5, M2 = 3;
  typedef struct {logic [8:0] d; logic e; int acc;} exp_t;
  logic clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [8:0] a_res, b_res, diff;
  int checks = 0, errors = 0, cyc = 0;
  logic prev_ov = 0;
  exp_t q[$];
  exp_t e;
  rns_sub_scheduler #(.M0(M0), .M1(M1), .M2(M2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_res(a_res), .b_res(b_res), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .out_err(out_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] pk(input int c0, input int c1, input int c2);
    return {3'(c2), 3'(c1), 3'(c0)};
  endfunction
  function automatic logic [9:0] model(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] r = '0;
    int m, x, y;
    for (int i = 0; i < 3; i++) begin
      m = i == 0 ? M0 : i == 1 ? M1 : M2;
      x = int'(a[3*i+:3]);
      y = int'(b[3*i+:3]);
      if (x >= m || y >= m) r[9] = 1'b1;
      else r[3*i+:3] = 3'((x - y + m) % m);
    end
    return r;
  endfunction
  task automatic push(input logic [8:0] a, input logic [8:0] b, input int acc);
    logic [9:0] r = model(a, b);
    q.push_back('{r[8:0], r[9], acc});
  endtask
  task automatic op(input logic [8:0] a, input logic [8:0] b);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1; a_res = a; b_res = b;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    else push(a, b, cyc + 1);
    @(posedge clk); #1;
    in_valid = 0; a_res = 9'($urandom); b_res = 9'($urandom);
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_diff"}, diff, 0);
    check({tag, "_out_err"}, out_err, 0);
  endtask
  // Monitor: latency on out_valid rise, result comparison on each output handshake
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 0;
    else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) check("unexpected_result", 1, 0);
        else check("latency", cyc - q[0].acc, 3);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("diff", diff, e.d);
        check("out_err", out_err, e.e);
      end
      prev_ov = out_valid;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, acc, last;
    logic [8:0] ra, rb, hold;
    rst_n = 0; in_valid = 0; out_ready = 1; a_res = 0; b_res = 0;
    #12;
    chk_reset_vals("reset");
    rst_n = 1;
    op(pk(6, 4, 2), pk(2, 1, 0));
    drain();
    op(pk(1, 0, 0), pk(5, 4, 2));
    drain();
    out_ready = 0;
    op(pk(6, 4, 2), pk(2, 1, 0));
    hold = model(pk(6, 4, 2), pk(2, 1, 0)) & 10'h1ff;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_reach_done", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1; a_res = 0; b_res = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff_hold", diff, hold);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("bp_in_ready_ret", in_ready, 1);
    check("bp_busy_ret", busy, 0);
    @(negedge clk);
    check("bp_no_accept", busy, 0);
    op(pk(3, 6, 1), pk(1, 2, 1));
    drain();
    op(pk(6, 4, 2), pk(2, 1, 0));
    drain();
    op(pk(1, 0, 0), pk(5, 4, 2));
    @(posedge clk); #1;
    rst_n = 0;
    q.delete();
    #1;
    chk_reset_vals("midreset");
    #5;
    rst_n = 1;
    op(pk(1, 0, 0), pk(5, 4, 2));
    drain();
    last = 0;
    @(posedge clk); #1;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ra = pk($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 2));
      rb = pk($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3));
      a_res = ra; b_res = rb;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      if (!in_ready) check("stream_accept_timeout", 0, 1);
      else begin
        acc = cyc + 1;
        push(ra, rb, acc);
        if (i > 0) check("stream_gap", acc - last, 5);
        last = acc;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rns_sub_scheduler.md
# rns_sub_scheduler

Sequencing controller for three-channel RNS modular subtraction using one shared 3-bit single-channel modular subtract datapath. Accepts two packed RNS operands over a parameterised moduli set and time-multiplexes the datapath across channels, one channel per cycle. Returns the packed residue difference with a valid/ready handshake. Sits between the RNS operand source (forward converter or register file) and downstream RNS arithmetic or reverse conversion.

## Interface
- M0, 7: modulus of channel 0; legal range 2..7.
- M1, 5: modulus of channel 1; legal range 2..7.
- M2, 3: modulus of channel 2; legal range 2..7.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock domain; the polarity and synchronicity of this reset are fixed.
- in_valid  in  1  operand pair present on a_res/b_res.
- in_ready  out  1  block can accept; high only in IDLE.
- a_res  in  9  minuend residues: [2:0] ch0, [5:3] ch1, [8:6] ch2.
- b_res  in  9  subtrahend residues, same packing.
- out_valid  out  1  diff/out_err valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- diff  out  9  (a − b) mod Mi per channel, same packing.
- out_err  out  1  at least one input residue was ≥ its modulus.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, DONE. Channel counter ch is 2 bits, values 0..2.
- IDLE: in_ready=1. When in_valid&in_ready, latch a_res and b_res, clear out_err, set ch=0, go to CALC. diff is not cleared on accept.
- CALC: each cycle, route channel ch residues a, b and modulus Mi to the shared subtractor, write diff[ch], then ch+1. After ch=2, go to DONE.
- Per-channel arithmetic:
  - Use 4-bit internal width. Result is a−b if a≥b, else a+Mi−b. Result is always < Mi for legal inputs.
  - If a≥Mi or b≥Mi: write 0 to that channel's diff and set out_err (sticky until next accept). Other channels are unaffected.
- DONE: out_valid=1; diff and out_err are held stable. On out_ready, go to IDLE. If out_ready is low, stay in DONE indefinitely.
- No overlap: in_valid outside IDLE is ignored and nothing is latched. in_valid in the cycle DONE→IDLE is also ignored, because in_ready=0 in that cycle.
- Input sampling: a_res and b_res are sampled only at the accept edge. Later changes to them do not affect the operation in flight.
- Asynchronous reset at any time, including mid-CALC or in DONE, forces IDLE, ch=0, and clears the latched operands, diff and out_err. The partial result is discarded. The first operation after reset deassertion behaves normally.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, diff=0, out_err=0.
- in_ready, out_valid and busy are decoded from state registers only, with no combinational path from in_valid or out_ready.
- Accept at edge k:
  - ch0, ch1 and ch2 are written at edges k+1, k+2 and k+3.
  - out_valid is high from edge k+3.
- Latency from accept to out_valid is 3 cycles.
- With out_ready held high:
  - DONE→IDLE occurs at edge k+4.
  - The next accept is possible at edge k+5, so the minimum issue interval is 5 cycles.
- diff[ch] updates exactly at its CALC edge; downstream may read it only while out_valid=1.

## Test plan
- Defaults (7,5,3): a ch0/1/2 = 6,4,2; b = 2,1,0; in_valid pulse → out_valid 3 cycles after accept; diff ch0/1/2 = 4,3,2; out_err=0.
- Wrap-around: a = 1,0,0; b = 5,4,2 → diff = 3,1,1; out_err=0.
- Backpressure: out_ready low 10 cycles after DONE → out_valid stays 1; diff stays constant; in_ready stays 0. A new in_valid with a=0,0,0 during this time is not latched. After out_ready=1, in_ready returns 1 the next cycle.
- Out-of-range: a = 3,6,1; b = 1,2,1 (ch1 residue 6 ≥ 5) → diff = 2,0,0; out_err=1. The next legal operation clears out_err.
- Reset mid-operation: assert rst_n=0 one cycle after accept (ch0 written) → outputs return to reset values immediately; after release, the wrap-around case gives correct results.
- Streaming: in_valid and out_ready tied high for 4 operations → accepts exactly every 5 cycles; each result matches its own operands.
